// File: rtl/fetch_queue.sv
// fetch_queue: circular (pc, instr) buffer between the instruction fetch and
// decode stages. It uses a valid/ready handshake on both sides and flushes
// synchronously on a redirect. The head entry is presented split into MIPS
// fields.
// Optional feature: define FETCHQ_BYPASS_EN to forward an offered instruction
// straight to the outputs while the queue is empty (0-cycle latency).
module fetch_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [31:0]   in_pc,
  input  logic [31:0]   in_instr,
  input  logic          flush,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [31:0]   out_pc,
  output logic [5:0]    opcode,
  output logic [4:0]    r_reg1,
  output logic [4:0]    r_reg2,
  output logic [4:0]    w_reg,
  output logic [4:0]    shift,
  output logic [5:0]    funct,
  output logic [15:0]   inst_16bit,
  output logic [31:0]   imm_sext,
  output logic [AW:0]   count
);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  entry_t          mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW:0]     count_q,  count_d;

  logic   empty, byp, push, pop;
  entry_t head;

  assign empty    = (count_q == '0);
  // A full queue refuses even when a pop happens in the same cycle, which
  // keeps in_ready independent of out_ready.
  assign in_ready = (count_q != FULL) && !flush;

`ifdef FETCHQ_BYPASS_EN
  assign byp = empty && in_valid && !flush;
`else
  assign byp = 1'b0;
`endif

  assign out_valid = !empty || byp;
  // A bypassed entry that decode takes right away is never written.
  assign push      = in_valid && in_ready && !(byp && out_ready);
  assign pop       = !empty && out_ready && !flush;

  // Head selection; the fields are forced to zero when nothing is valid.
  always_comb begin
    head = '0;
    if (byp)            head = '{pc: in_pc, instr: in_instr};
    else if (!empty)    head = mem_q[rd_ptr_q];
  end

  assign out_pc     = head.pc;
  assign opcode     = head.instr[31:26];
  assign r_reg1     = head.instr[25:21];
  assign r_reg2     = head.instr[20:16];
  assign w_reg      = head.instr[15:11];
  assign shift      = head.instr[10:6];
  assign funct      = head.instr[5:0];
  assign inst_16bit = head.instr[15:0];
  assign imm_sext   = {{16{head.instr[15]}}, head.instr[15:0]};
  assign count      = count_q;

  // Next-state for pointers and occupancy; flush overrides everything.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      if (push && !pop)      count_d = count_q + (AW+1)'(1);
      else if (pop && !push) count_d = count_q - (AW+1)'(1);
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; its contents are meaningless until written, so no reset.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= '{pc: in_pc, instr: in_instr};
  end

endmodule

// File: tb/tb_fetch_queue.sv
module tb_fetch_queue;
  localparam int DEPTH = 4;
  localparam int AW    = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, flush, out_valid, out_ready;
  logic [31:0] in_pc, in_instr, out_pc, imm_sext;
  logic [5:0]  opcode, funct;
  logic [4:0]  r_reg1, r_reg2, w_reg, shift;
  logic [15:0] inst_16bit;
  logic [AW:0] count;

  fetch_queue #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_instr(in_instr),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .opcode(opcode), .r_reg1(r_reg1), .r_reg2(r_reg2), .w_reg(w_reg),
    .shift(shift), .funct(funct), .inst_16bit(inst_16bit), .imm_sext(imm_sext),
    .count(count)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  typedef struct { logic [31:0] pc; logic [31:0] instr; } ent_t;
  ent_t sb[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One cycle: drive inputs after the falling edge, check settled outputs
  // against the scoreboard, then advance the model across the rising edge.
  task automatic cyc(input logic v, input logic [31:0] pc, input logic [31:0] ins,
                     input logic ordy, input logic fl);
    logic        exp_rdy, byp, exp_ov, do_push, do_pop;
    logic [31:0] e_pc, e_in;
    int          mcnt;
    in_valid = v; in_pc = pc; in_instr = ins; out_ready = ordy; flush = fl;
    #1;
    mcnt    = sb.size();
    exp_rdy = (mcnt != DEPTH) && !fl;
    byp     = 1'b0;
`ifdef FETCHQ_BYPASS_EN
    byp     = (mcnt == 0) && v && !fl;
`endif
    exp_ov  = (mcnt != 0) || byp;
    e_pc = '0; e_in = '0;
    if (byp)           begin e_pc = pc;        e_in = ins;         end
    else if (mcnt > 0) begin e_pc = sb[0].pc;  e_in = sb[0].instr; end
    chk("in_ready",   {31'b0, in_ready},  {31'b0, exp_rdy});
    chk("count",      {29'b0, count},     mcnt);
    chk("out_valid",  {31'b0, out_valid}, {31'b0, exp_ov});
    chk("out_pc",     out_pc,             e_pc);
    chk("opcode",     {26'b0, opcode},    {26'b0, e_in[31:26]});
    chk("r_reg1",     {27'b0, r_reg1},    {27'b0, e_in[25:21]});
    chk("r_reg2",     {27'b0, r_reg2},    {27'b0, e_in[20:16]});
    chk("w_reg",      {27'b0, w_reg},     {27'b0, e_in[15:11]});
    chk("shift",      {27'b0, shift},     {27'b0, e_in[10:6]});
    chk("funct",      {26'b0, funct},     {26'b0, e_in[5:0]});
    chk("inst_16bit", {16'b0, inst_16bit},{16'b0, e_in[15:0]});
    chk("imm_sext",   imm_sext,           {{16{e_in[15]}}, e_in[15:0]});
    if (fl) sb.delete();
    else begin
      do_pop  = exp_ov && ordy;
      do_push = v && exp_rdy && !(byp && ordy);
      if (do_pop && !byp) void'(sb.pop_front());
      if (do_push) sb.push_back('{pc: pc, instr: ins});
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 0; in_pc = '0; in_instr = '0; out_ready = 0; flush = 0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_in_ready",  {31'b0, in_ready},  32'd1);
    chk("rst_count",     {29'b0, count},     32'd0);
    chk("rst_out_pc",    out_pc,             32'd0);
    chk("rst_imm_sext",  imm_sext,           32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single add instruction: push, then pop on the next cycle.
    cyc(1, 32'h0, 32'h012A4020, 1, 0);
    chk("fields_r_reg1", {27'b0, r_reg1}, 32'd9);
    cyc(0, 0, 0, 1, 0);
    cyc(0, 0, 0, 1, 0);

    // Fill to DEPTH with decode stalled, offer a fifth, then drain.
    cyc(1, 32'h10, 32'h2108FFFC, 0, 0);
    cyc(1, 32'h14, 32'h8D09000C, 0, 0);
    cyc(1, 32'h18, 32'h01095022, 0, 0);
    cyc(1, 32'h1C, 32'h1000FFFE, 0, 0);
    chk("full_imm_sext", imm_sext, 32'hFFFFFFFC);
    chk("full_opcode",   {26'b0, opcode}, 32'h08);
    cyc(1, 32'h50, 32'hDEADBEEF, 0, 0);   // refused
    cyc(1, 32'h50, 32'hDEADBEEF, 1, 0);   // full + pop: still refused
    cyc(1, 32'h54, 32'hCAFE0001, 1, 0);   // accepted after the pop
    repeat (5) cyc(0, 0, 0, 1, 0);

    // Streaming push+pop with pointer wrap.
    for (int i = 0; i < 10; i++)
      cyc(1, 32'(i * 4), 32'h20000000 | 32'(i * 16'h1111), 1, 0);
    cyc(0, 0, 0, 1, 0);
    cyc(0, 0, 0, 1, 0);

    // Flush with an offer pending; the offered entry must never appear.
    cyc(1, 32'h60, 32'h00000001, 0, 0);
    cyc(1, 32'h64, 32'h00000002, 0, 0);
    cyc(1, 32'h68, 32'h00000003, 0, 0);
    cyc(1, 32'h99, 32'h0000BEEF, 1, 1);
    cyc(0, 0, 0, 1, 0);
    cyc(1, 32'h100, 32'hAC0F8000, 1, 0);
    cyc(0, 0, 0, 1, 0);
    cyc(0, 0, 0, 1, 0);

    // Asynchronous reset in the middle of a cycle.
    cyc(1, 32'h200, 32'h11111111, 0, 0);
    cyc(1, 32'h204, 32'h22222222, 0, 0);
    in_valid = 0;
    #2 rst_n = 1'b0;
    #1;
    chk("async_out_valid", {31'b0, out_valid}, 32'd0);
    chk("async_count",     {29'b0, count},     32'd0);
    chk("async_in_ready",  {31'b0, in_ready},  32'd1);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;

    // Push on the first edge after reset release; with bypass enabled this
    // one is consumed in the same cycle.
    cyc(1, 32'h40, 32'h3C010040, 1, 0);
    cyc(0, 0, 0, 1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
